// File: rtl/tap_scan_pkg.sv
// Shared types and constants for the tap scan controller and its delay line.
package tap_scan_pkg;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned FILL_W = 3;

  typedef enum logic {
    ACCEPT = 1'b0,
    SCAN   = 1'b1
  } state_e;

  // Increment a fill count, saturating at max.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f,
                                                 input logic [FILL_W-1:0] max);
    return (f >= max) ? f : f + FILL_W'(1);
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Four-stage shift register of WIDTH-bit samples with a tap select mux.
module tap_delay_line
  import tap_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] taps_q [DEPTH];

  // Clear wins over shift; otherwise taps hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) taps_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) taps_q[i] <= '0;
    end else if (shift_en_i) begin
      taps_q[0] <= din_i;
      for (int i = 1; i < int'(DEPTH); i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign dout_o = taps_q[sel_i];

endmodule

// File: rtl/tap_scan_ctrl.sv
// Delay-line controller: accepts samples into four taps, then scans filled taps
// out newest-first over a valid/ready handshake.
module tap_scan_ctrl
  import tap_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              scan_req,
  input  logic              flush,
  output logic [WIDTH-1:0]  out_data,
  output logic [IDX_W-1:0]  out_tap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [FILL_W-1:0] fill,
  output logic              busy
);

  state_e            state_q;
  logic [FILL_W-1:0] fill_q;
  logic [IDX_W-1:0]  idx_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic              push_c;
  logic              last_c;
  logic [FILL_W-1:0] fill_post_c;
  logic [WIDTH-1:0]  tap_sel_c;

  // A push coincident with flush is dropped.
  assign push_c      = in_valid && in_ready_q && !flush;
  assign fill_post_c = push_c ? fill_inc(fill_q, FILL_W'(DEPTH)) : fill_q;
  assign last_c      = out_valid_q && (FILL_W'(idx_q) == (fill_q - FILL_W'(1)));

  tap_delay_line #(
    .WIDTH (WIDTH)
  ) u_delay_line (
    .clk_i      (clk),
    .rst_i      (reset),
    .shift_en_i (push_c),
    .clr_i      (flush),
    .din_i      (in_data),
    .sel_i      (idx_q),
    .dout_o     (tap_sel_c)
  );

  // FSM, fill and idx counters; handshake flags are coded alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCEPT;
      fill_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ACCEPT;
      fill_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ACCEPT: begin
          fill_q <= fill_post_c;
          if (scan_req && (fill_post_c != '0)) begin
            state_q     <= SCAN;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (last_c) begin
              state_q     <= ACCEPT;
              idx_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ACCEPT;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_valid_q ? tap_sel_c : '0;
  assign out_tap   = idx_q;
  assign out_last  = last_c;
  assign fill      = fill_q;

endmodule

// File: tb/tb_tap_scan_ctrl.sv
// Directed bench for tap_scan_ctrl with hand-computed expectations.
module tb_tap_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       scan_req;
  logic       flush;
  logic [7:0] out_data;
  logic [1:0] out_tap;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] fill;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  tap_scan_ctrl #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scan_req  (scan_req),
    .flush     (flush),
    .out_data  (out_data),
    .out_tap   (out_tap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .fill      (fill),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tap(input string tag, input logic [31:0] d, input logic [31:0] t,
                         input logic [31:0] l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  d);
    chk({tag, "_tap"},   32'(out_tap),   t);
    chk({tag, "_last"},  32'(out_last),  l);
  endtask

  task automatic chk_accept(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready),  32'd1);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; scan_req = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    chk_accept("rst");
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_tap",  32'(out_tap),  32'd0);
    chk("rst_fill", 32'(fill),     32'd0);
    step(); step();
    reset = 1'b0;

    // Four pushes, full scan newest-first
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    chk("fill4", 32'(fill), 32'd4);
    scan_req = 1'b1; out_ready = 1'b1;
    step();
    scan_req = 1'b0;
    chk("scan_busy",  32'(busy),     32'd1);
    chk("scan_ready", 32'(in_ready), 32'd0);
    chk_tap("s1t0", 32'hD4, 32'd0, 32'd0);
    step(); chk_tap("s1t1", 32'hC3, 32'd1, 32'd0);
    step(); chk_tap("s1t2", 32'hB2, 32'd2, 32'd0);
    step(); chk_tap("s1t3", 32'hA1, 32'd3, 32'd1);
    step(); chk_accept("s1end");
    chk("s1end_fill", 32'(fill), 32'd4);

    // Partial fill; the second push coincides with scan_req
    do_flush();
    chk("flush_fill", 32'(fill), 32'd0);
    push(8'h11);
    in_valid = 1'b1; in_data = 8'h22; scan_req = 1'b1;
    step();
    in_valid = 1'b0; scan_req = 1'b0;
    chk_tap("s2t0", 32'h22, 32'd0, 32'd0);
    chk("s2_fill", 32'(fill), 32'd2);
    step(); chk_tap("s2t1", 32'h11, 32'd1, 32'd1);
    step(); chk_accept("s2end");
    chk("s2end_fill", 32'(fill), 32'd2);

    // Overflow: oldest sample discarded, fill saturates
    do_flush();
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("s3_fill", 32'(fill), 32'd4);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    chk_tap("s3t0", 32'h05, 32'd0, 32'd0);
    step(); chk_tap("s3t1", 32'h04, 32'd1, 32'd0);
    step(); chk_tap("s3t2", 32'h03, 32'd2, 32'd0);
    step(); chk_tap("s3t3", 32'h02, 32'd3, 32'd1);
    step(); chk_accept("s3end");

    // Backpressure on tap 1 with a push attempted during the stall
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    chk_tap("s4t0", 32'h05, 32'd0, 32'd0);
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_tap("stall", 32'h04, 32'd1, 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step(); chk_tap("s4t2", 32'h03, 32'd2, 32'd0);
    step(); chk_tap("s4t3", 32'h02, 32'd3, 32'd1);
    step(); chk_accept("s4end");
    chk("s4_fill", 32'(fill), 32'd4);

    // Next scan proves the stalled push was not taken; flush aborts on tap 2
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    chk_tap("s5t0", 32'h05, 32'd0, 32'd0);
    step(); chk_tap("s5t1", 32'h04, 32'd1, 32'd0);
    step(); chk_tap("s5t2", 32'h03, 32'd2, 32'd0);
    do_flush();
    chk_accept("flushed");
    chk("flushed_fill", 32'(fill), 32'd0);
    chk("flushed_data", 32'(out_data), 32'd0);

    // Push coincident with flush is dropped; scan_req on empty is ignored
    in_valid = 1'b1; in_data = 8'h55;
    do_flush();
    in_valid = 1'b0;
    chk("flush_push_fill", 32'(fill), 32'd0);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    chk_accept("empty_scan");

    // Async reset mid-scan, then first push right after release
    push(8'h33); push(8'h44);
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    chk_tap("s6t0", 32'h44, 32'd0, 32'd0);
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_accept("async_rst");
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_fill", 32'(fill),     32'd0);
    step();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h7E; scan_req = 1'b1;
    step();
    in_valid = 1'b0; scan_req = 1'b0;
    chk_tap("s7t0", 32'h7E, 32'd0, 32'd1);
    chk("s7_fill", 32'(fill), 32'd1);
    out_ready = 1'b1;
    step(); chk_accept("s7end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tap_scan_ctrl.md
TAP_SCAN_CTRL -- requirements
Module: tap_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the data width of every tap and data port.
REQ-002 SHALL have parameter DEPTH, default 4, setting the number of delay taps; values other than 4 are unsupported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: the sample to push into tap 0.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a push this cycle.
REQ-008 SHALL have port scan_req, input, 1 bit: request a read-out of all filled taps.
REQ-009 SHALL have port flush, input, 1 bit: synchronous clear of taps, fill and scan.
REQ-010 SHALL have port out_data, output, WIDTH bits: the value of the tap currently being presented.
REQ-011 SHALL have port out_tap, output, 2 bits: the index of the presented tap.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-014 SHALL have port out_last, output, 1 bit: the presented tap is the final one of the scan.
REQ-015 SHALL have port fill, output, 3 bits: the number of valid taps, 0..4.
REQ-016 SHALL have port busy, output, 1 bit: a scan is in progress.

Function
REQ-017 SHALL implement two states: ACCEPT and SCAN.
REQ-018 In ACCEPT: SHALL drive in_ready=1, out_valid=0, busy=0.
REQ-019 In SCAN: SHALL drive in_ready=0, out_valid=1, busy=1.
REQ-020 A push occurs when in_valid && in_ready; on a push, SHALL shift tap0<=in_data, tap1<=tap0, tap2<=tap1, tap3<=tap2, with tap3's old value discarded.
REQ-021 Without a push, taps SHALL hold.
REQ-022 On a push, fill SHALL increment and saturate at 4.
REQ-023 On scan_req in ACCEPT with post-push fill>0: SHALL enter SCAN next cycle with idx=0.
REQ-024 On scan_req in ACCEPT with post-push fill==0: SHALL ignore the request.
REQ-025 If push and scan_req coincide: the push SHALL complete first, and the scan SHALL present the updated taps.
REQ-026 In SCAN: out_data=tap[idx], out_tap=idx, out_last=(idx==fill-1); outputs combinational from registers.
REQ-027 In SCAN on out_valid && out_ready: if out_last, SHALL return to ACCEPT next cycle; else idx SHALL increment.
REQ-028 Without out_ready in SCAN: SHALL hold out_data, out_tap and out_last stable.
REQ-029 During SCAN: taps and fill SHALL be frozen, and scan_req SHALL be ignored.
REQ-030 Latency: out_valid SHALL rise the cycle after scan_req is sampled; each tap SHALL take at least 1 cycle.
REQ-031 Back-to-back scans: SHALL allow at least one ACCEPT cycle between scans.
REQ-032 flush SHALL have highest priority: taps=0, fill=0, state=ACCEPT, idx=0 next cycle, aborting any scan without asserting out_last.
REQ-033 A push coincident with flush SHALL be dropped.
REQ-034 out_tap width SHALL equal clog2(DEPTH).

Reset
REQ-035 reset SHALL act asynchronously: state=ACCEPT, taps=0, fill=0, idx=0.
REQ-036 While reset is asserted, outputs SHALL read out_valid=0, out_last=0, busy=0, in_ready=1, out_data=0, out_tap=0.
REQ-037 Reset asserted mid-scan SHALL abort the scan immediately, and no handshake SHALL complete.
REQ-038 The first push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-039 Package tap_scan_pkg SHALL hold the state enum (ACCEPT, SCAN), the DEPTH constant (4) and the IDX_W constant (2).
REQ-040 Sub-module tap_delay_line SHALL be the 4-stage WIDTH-bit shift register, with inputs shift_en and clr and a 2-bit tap select mux.
REQ-041 tap_scan_ctrl SHALL contain the FSM, the fill counter and the idx counter.

Verification
REQ-042 Reset, push A1,B2,C3,D4 on consecutive cycles, scan_req, out_ready=1 -> fill=4; outputs D4/0, C3/1, B2/2, A1/3 with out_last on A1; then ACCEPT.
REQ-043 Push 11,22 only, scan with out_ready=1 -> outputs 22/0, 11/1 with out_last on tap 1; fill stays 2.
REQ-044 Push 5 samples 01..05, then scan -> outputs 05,04,03,02; 01 is discarded; fill=4.
REQ-045 Scan with out_ready held low for 3 cycles on tap 1 -> out_data and out_tap stable for 3 cycles; in_ready=0; a push attempted then is not taken.
REQ-046 flush asserted during tap 2 of a scan -> next cycle out_valid=0, fill=0, taps 0; scan_req with fill=0 is ignored.
REQ-047 reset pulse mid-scan -> out_valid drops without waiting for a clock edge; after release, push 7E and scan -> output 7E/0 with out_last.
